bcd_down_timer: RTL and testbench
=================================

Name: bcd_down_timer

Overview:
Multi-digit BCD down-counter (countdown timer), the decrementing counterpart to the team's up-counting BCD counter. It takes a preset BCD value and counts down by one on each clk_en pulse until it reaches zero, then signals completion. It sits in the same clock-enabled datapath and drives the same BCD display/output path through sal.

Parameters:
DIGITS, 2, number of BCD digits; sal and load_val are 4*DIGITS bits, digit 0 in bits [3:0].

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
clk_en  input  1  count enable pulse; one decrement per clk_en=1 cycle while RUN
load  input  1  load load_val into counter, return to IDLE
load_val  input  4*DIGITS  BCD preset value
start  input  1  begin/resume countdown
stop  input  1  pause countdown
sal  output  4*DIGITS  current BCD count (registered)
busy  output  1  1 in RUN or PAUSE (registered)
done  output  1  one-cycle completion pulse (registered)
zero  output  1  combinational, 1 when sal == 0

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: sal=0, state=IDLE, busy=0, done=0, so zero=1.
- States: IDLE, RUN, PAUSE, DONE.
- Priority per edge: rst > load > stop > start > count.
- load (any state): each digit of load_val is written to sal. A digit value >9 is clamped to 9. Next state is IDLE, busy=0, done=0. Any in-progress count is abandoned.
- IDLE:
  - start with sal!=0 -> RUN, busy=1.
  - start with sal==0 -> ignored: stays IDLE, no done.
- RUN:
  - clk_en=0: sal holds.
  - clk_en=1: sal decrements by 1 in BCD. Digit 0 decrements; a digit at 0 wraps to 9 and borrows from the next digit. Borrow ripples across all DIGITS in the same cycle.
  - When the decrement takes sal to 0 (sal was 0...01): next state is DONE, sal=0, done=1, busy=0, all on that same edge.
  - stop -> PAUSE. No decrement on that edge, even if clk_en=1.
- PAUSE:
  - sal holds regardless of clk_en; busy=1.
  - start -> RUN. Decrementing begins on the next clk_en after entering RUN, not on the resume edge.
  - stop and start together: stop wins, stays PAUSE.
- DONE: lasts exactly one cycle (done=1), then unconditionally IDLE with done=0. load or rst during DONE takes effect per the priority order.
- sal never underflows: at 0 the counter is never in RUN.
- Never-decrement rule: sal changes only on load, rst, or a RUN-state clk_en decrement.
- All outputs except zero are registered; there is no combinational path from inputs to sal, busy or done.
- Every sal digit is always a valid BCD value (0-9).

Test Plan (DIGITS=2):
1. Reset: assert rst for 2 cycles -> sal=8'h00, busy=0, done=0, zero=1.
2. Full countdown:
   - Stimulus: load 8'h12, then start, clk_en=1 every cycle.
   - Required: sal steps 12,11,10,09,...,01,00, with 10->09 showing the borrow.
   - Required: done=1 for exactly one cycle on the edge sal becomes 00, busy falls on the same edge, then IDLE.
3. Gated enable:
   - Stimulus: load 8'h03, start, clk_en high one cycle in every 4.
   - Required: sal reaches 00 after exactly 3 clk_en pulses (~12 cycles); sal is stable between pulses.
4. Pause/resume:
   - Stimulus: during RUN at sal=8'h07, pulse stop, then hold clk_en=1 for 5 cycles.
   - Required during pause: sal stays 07, busy=1.
   - Stimulus: pulse start. Required: next clk_en gives 06. stop+start in the same cycle keeps PAUSE.
5. Clamp and zero-start:
   - Stimulus: load 8'h1F. Required: sal=8'h19.
   - Stimulus: load 8'h00, then start. Required: stays IDLE, busy=0, done never asserted.
6. Mid-operation override:
   - Stimulus: rst during RUN at sal=8'h05. Required: next cycle sal=00, busy=0, done=0.
   - Stimulus: load 8'h42 during RUN with clk_en=1. Required: sal=42, IDLE, no decrement that edge.

Source files
------------

// File: rtl/bcd_down_timer.sv
// bcd_down_timer: multi-digit BCD countdown timer with load, start/stop
// control, a one-cycle completion pulse and a combinational zero flag.
module bcd_down_timer #(
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  stop,
  output logic [4*DIGITS-1:0]   sal,
  output logic                  busy,
  output logic                  done,
  output logic                  zero
);

  localparam int unsigned W = 4 * DIGITS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] sal_q, sal_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  // BCD decrement by one; borrow ripples through every digit in one step.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Saturate each preset digit to 9 so the count is always valid BCD.
  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Next-state and next-output logic; priority load > stop > start > count.
  always_comb begin
    logic [W-1:0] dec_val;
    state_d = state_q;
    sal_d   = sal_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dec_val = bcd_dec(sal_q);
    if (load) begin
      sal_d   = bcd_clamp(load_val);
      state_d = ST_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          busy_d = 1'b0;
          if (!stop && start && (sal_q != '0)) begin
            state_d = ST_RUN;
            busy_d  = 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_PAUSE;
          end else if (clk_en) begin
            sal_d = dec_val;
            if (dec_val == '0) begin
              state_d = ST_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (!stop && start) state_d = ST_RUN;
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sal_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sal_q   <= sal_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sal  = sal_q;
  assign busy = busy_q;
  assign done = done_q;
  assign zero = (sal_q == '0);

endmodule

// File: tb/tb_bcd_down_timer.sv
// Scoreboard bench for bcd_down_timer: the driver pushes the hand-computed
// post-edge expectation of every cycle; a monitor pops and compares.
module tb_bcd_down_timer;

  logic       clk = 1'b0;
  logic       rst, clk_en, load, start, stop;
  logic [7:0] load_val;
  logic [7:0] sal;
  logic       busy, done, zero;

  typedef struct {
    logic [7:0] sal;
    logic       busy;
    logic       done;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  bcd_down_timer #(.DIGITS(2)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .sal(sal), .busy(busy), .done(done), .zero(zero)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the expected state after the edge.
  task automatic step(input logic r, input logic ld, input logic [7:0] lv,
                      input logic st, input logic sp, input logic en,
                      input logic [7:0] es, input logic eb, input logic ed,
                      input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; load = ld; load_val = lv; start = st; stop = sp; clk_en = en;
    e.sal = es; e.busy = eb; e.done = ed; e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: one registered output set per clock, compared against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (sal !== e.sal || busy !== e.busy || done !== e.done ||
            zero !== (e.sal == 8'h00)) begin
          failures++;
          $display("FAIL %s: got sal=%h busy=%b done=%b zero=%b, want sal=%h busy=%b done=%b zero=%b",
                   e.name, sal, busy, done, zero, e.sal, e.busy, e.done, (e.sal == 8'h00));
        end
      end
    end
  end

  initial begin
    logic [7:0] down12 [12];
    down12 = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
               8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
    rst = 1'b0; clk_en = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
    load_val = 8'h00;

    // 1. reset
    step(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, "reset_a");
    step(1, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, "reset_b");
    step(0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, "reset_idle");

    // 2. full countdown from 12
    step(0, 1, 8'h12, 0, 0, 0, 8'h12, 0, 0, "load12");
    step(0, 0, 8'h00, 1, 0, 0, 8'h12, 1, 0, "start12");
    for (int i = 0; i < 12; i++)
      step(0, 0, 8'h00, 0, 0, 1, down12[i], (i < 11), (i == 11), "count12");
    step(0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, "after_done12");
    step(0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, "idle_hold");

    // 3. gated enable, one pulse in four
    step(0, 1, 8'h03, 0, 0, 0, 8'h03, 0, 0, "load03");
    step(0, 0, 8'h00, 1, 0, 0, 8'h03, 1, 0, "start03");
    for (int k = 0; k < 3; k++) begin
      for (int q = 0; q < 3; q++)
        step(0, 0, 8'h00, 0, 0, 0, 8'(3 - k), 1, 0, "gated_hold");
      step(0, 0, 8'h00, 0, 0, 1, 8'(2 - k), (k < 2), (k == 2), "gated_pulse");
    end
    step(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, "gated_idle");

    // 4. pause / resume
    step(0, 1, 8'h08, 0, 0, 0, 8'h08, 0, 0, "load08");
    step(0, 0, 8'h00, 1, 0, 0, 8'h08, 1, 0, "start08");
    step(0, 0, 8'h00, 0, 0, 1, 8'h07, 1, 0, "dec07");
    step(0, 0, 8'h00, 0, 1, 1, 8'h07, 1, 0, "stop_no_dec");
    for (int i = 0; i < 5; i++)
      step(0, 0, 8'h00, 0, 0, 1, 8'h07, 1, 0, "pause_hold");
    step(0, 0, 8'h00, 1, 0, 1, 8'h07, 1, 0, "resume_no_dec");
    step(0, 0, 8'h00, 0, 0, 1, 8'h06, 1, 0, "resume_dec06");
    step(0, 0, 8'h00, 0, 1, 0, 8'h06, 1, 0, "stop2");
    step(0, 0, 8'h00, 1, 1, 1, 8'h06, 1, 0, "stop_start_pause");
    step(0, 0, 8'h00, 0, 0, 1, 8'h06, 1, 0, "still_paused");
    step(0, 0, 8'h00, 1, 0, 0, 8'h06, 1, 0, "resume2");
    step(0, 0, 8'h00, 0, 0, 1, 8'h05, 1, 0, "dec05");

    // 6. reset during RUN at 05
    step(1, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, "rst_in_run");
    step(0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, "post_rst");

    // 6. load during RUN with clk_en
    step(0, 1, 8'h50, 0, 0, 0, 8'h50, 0, 0, "load50");
    step(0, 0, 8'h00, 1, 0, 0, 8'h50, 1, 0, "start50");
    step(0, 0, 8'h00, 0, 0, 1, 8'h49, 1, 0, "borrow49");
    step(0, 1, 8'h42, 0, 0, 1, 8'h42, 0, 0, "load42_in_run");
    step(0, 0, 8'h00, 0, 0, 1, 8'h42, 0, 0, "idle_after_load");

    // 5. clamp and zero-start
    step(0, 1, 8'h1F, 0, 0, 0, 8'h19, 0, 0, "clamp1F");
    step(0, 1, 8'hAF, 0, 0, 0, 8'h99, 0, 0, "clampAF");
    step(0, 0, 8'h00, 1, 0, 0, 8'h99, 1, 0, "start99");
    step(0, 0, 8'h00, 0, 0, 1, 8'h98, 1, 0, "dec98");
    step(0, 1, 8'h00, 0, 0, 1, 8'h00, 0, 0, "load00");
    step(0, 0, 8'h00, 1, 0, 1, 8'h00, 0, 0, "start_zero_a");
    step(0, 0, 8'h00, 1, 0, 1, 8'h00, 0, 0, "start_zero_b");
    step(0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, "zero_idle");

    // 2. done pulse straight after a load of 01
    step(0, 1, 8'h01, 0, 0, 0, 8'h01, 0, 0, "load01");
    step(0, 0, 8'h00, 1, 0, 1, 8'h01, 1, 0, "start01");
    step(0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 1, "done01");
    step(0, 0, 8'h00, 1, 0, 1, 8'h00, 0, 0, "done01_clear");

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
